// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared FSMC packet buffer constants and access owner encoding
package fsmc_pkg;

  localparam int FSMC_AW = 9;
  localparam int FSMC_DW = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_FAB  = 2'd2
  } owner_e;

endpackage

// File: rtl/fsmc_buf_arbiter.sv
// rtl/fsmc_buf_arbiter.sv - host/fabric arbiter for the single-port FSMC packet buffer
module fsmc_buf_arbiter
  import fsmc_pkg::*;
#(
  parameter int AW         = FSMC_AW,
  parameter int DW         = FSMC_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic [DW-1:0] h_rdata,
  output logic          h_rvalid,
  output logic          h_busy,
  output logic          h_ovf,
  input  logic          f_req,
  input  logic          f_we,
  input  logic [AW-1:0] f_addr,
  input  logic [DW-1:0] f_wdata,
  output logic          f_gnt,
  output logic [DW-1:0] f_rdata,
  output logic          f_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic          skid_vld_q, skid_vld_d;
  logic          skid_we_q, skid_we_d;
  logic [AW-1:0] skid_addr_q, skid_addr_d;
  logic [DW-1:0] skid_wdata_q, skid_wdata_d;
  logic [CW-1:0] starve_q, starve_d;
  owner_e        own_q, own_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic          h_ovf_q, h_ovf_d;

  logic force_fab;
  logic skid_issue;
  logic host_direct;

  always_comb begin
    force_fab   = f_req && (starve_q == STARVE_LIM);
    f_gnt       = 1'b0;
    skid_issue  = 1'b0;
    host_direct = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    own_d       = OWN_NONE;

    // Nothing reaches the RAM while reset is asserted, even with requests present.
    if (reset_l) begin
      if (force_fab)       f_gnt       = 1'b1;
      else if (skid_vld_q) skid_issue  = 1'b1;
      else if (h_req)      host_direct = 1'b1;
      else if (f_req)      f_gnt       = 1'b1;
    end

    if (f_gnt) begin
      mem_en    = 1'b1;
      mem_we    = f_we;
      mem_addr  = f_addr;
      mem_wdata = f_wdata;
      own_d     = f_we ? OWN_NONE : OWN_FAB;
    end else if (skid_issue) begin
      mem_en    = 1'b1;
      mem_we    = skid_we_q;
      mem_addr  = skid_addr_q;
      mem_wdata = skid_wdata_q;
      own_d     = skid_we_q ? OWN_NONE : OWN_HOST;
    end else if (host_direct) begin
      mem_en    = 1'b1;
      mem_we    = h_we;
      mem_addr  = h_addr;
      mem_wdata = h_wdata;
      own_d     = h_we ? OWN_NONE : OWN_HOST;
    end

    skid_vld_d   = skid_vld_q && !skid_issue;
    skid_we_d    = skid_we_q;
    skid_addr_d  = skid_addr_q;
    skid_wdata_d = skid_wdata_q;
    h_ovf_d      = h_ovf_q;
    // Skid occupancy is judged at cycle start: a draining entry still blocks a new one.
    if (reset_l && h_req && !host_direct) begin
      if (!skid_vld_q) begin
        skid_vld_d   = 1'b1;
        skid_we_d    = h_we;
        skid_addr_d  = h_addr;
        skid_wdata_d = h_wdata;
      end else begin
        h_ovf_d = 1'b1;
      end
    end

    starve_d = '0;
    if (f_req && !f_gnt) starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
  end

  assign h_rvalid  = (own_q == OWN_HOST);
  assign f_rvalid  = (own_q == OWN_FAB);
  assign h_rdata   = h_rvalid ? mem_rdata : h_rdata_q;
  assign f_rdata   = f_rvalid ? mem_rdata : f_rdata_q;
  assign h_rdata_d = h_rdata;
  assign f_rdata_d = f_rdata;
  assign h_busy    = skid_vld_q;
  assign h_ovf     = h_ovf_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      skid_vld_q   <= 1'b0;
      skid_we_q    <= 1'b0;
      skid_addr_q  <= '0;
      skid_wdata_q <= '0;
      starve_q     <= '0;
      own_q        <= OWN_NONE;
      h_rdata_q    <= '0;
      f_rdata_q    <= '0;
      h_ovf_q      <= 1'b0;
    end else begin
      skid_vld_q   <= skid_vld_d;
      skid_we_q    <= skid_we_d;
      skid_addr_q  <= skid_addr_d;
      skid_wdata_q <= skid_wdata_d;
      starve_q     <= starve_d;
      own_q        <= own_d;
      h_rdata_q    <= h_rdata_d;
      f_rdata_q    <= f_rdata_d;
      h_ovf_q      <= h_ovf_d;
    end
  end

endmodule

// File: tb/tb_fsmc_buf_arbiter.sv
// tb/tb_fsmc_buf_arbiter.sv - randomized and directed bench for fsmc_buf_arbiter
module tb_fsmc_buf_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        h_req, h_we, f_req, f_we;
  logic [8:0]  h_addr, f_addr, mem_addr;
  logic [15:0] h_wdata, f_wdata, h_rdata, f_rdata, mem_wdata, mem_rdata;
  logic        h_rvalid, h_busy, h_ovf, f_gnt, f_rvalid, mem_en, mem_we;

  int checks = 0;
  int errors = 0;

  fsmc_buf_arbiter #(.AW(9), .DW(16), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_l(reset_l),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(h_rdata), .h_rvalid(h_rvalid), .h_busy(h_busy), .h_ovf(h_ovf),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_gnt(f_gnt), .f_rdata(f_rdata), .f_rvalid(f_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [8:0] a);
    return (a == 9'h1FF) ? 16'hBEEF : {a[6:0], a};
  endfunction

  // Registered-output single-port RAM standing in for buf_ram_sp
  logic [15:0] ram [512];
  bit          written [512];
  logic [15:0] ram_q;
  assign mem_rdata = ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        ram_q <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // Reference model state
  logic [15:0] mm [512];
  bit          m_skid_v, m_skid_we, m_ovf, m_hpend, m_fpend, m_last_fgnt;
  logic [8:0]  m_skid_a;
  logic [15:0] m_skid_d, m_hnext, m_fnext, m_hheld, m_fheld;
  int          m_starve;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_skid_v = 0; m_skid_we = 0; m_skid_a = '0; m_skid_d = '0;
    m_ovf = 0; m_hpend = 0; m_fpend = 0; m_last_fgnt = 0;
    m_hheld = '0; m_fheld = '0; m_starve = 0;
  endtask

  // One clock: drive inputs, check DUT against the model, then advance the model.
  task automatic step(input bit hr, input bit hwe, input logic [8:0] ha, input logic [15:0] hd,
                      input bit fr, input bit fwe, input logic [8:0] fa, input logic [15:0] fd);
    int          win; // 0 idle, 1 fabric, 2 skid, 3 host
    bit          e_we, was_full;
    logic [8:0]  e_a;
    logic [15:0] e_d;
    @(negedge clk);
    h_req = hr; h_we = hwe; h_addr = ha; h_wdata = hd;
    f_req = fr; f_we = fwe; f_addr = fa; f_wdata = fd;
    #1;
    chk_eq("h_rvalid", h_rvalid, m_hpend);
    if (m_hpend) m_hheld = m_hnext;
    chk_eq("h_rdata", h_rdata, m_hheld);
    chk_eq("f_rvalid", f_rvalid, m_fpend);
    if (m_fpend) m_fheld = m_fnext;
    chk_eq("f_rdata", f_rdata, m_fheld);
    chk_eq("h_busy", h_busy, m_skid_v);
    chk_eq("h_ovf", h_ovf, m_ovf);

    if (fr && m_starve == SM) win = 1;
    else if (m_skid_v)         win = 2;
    else if (hr)               win = 3;
    else if (fr)               win = 1;
    else                       win = 0;
    case (win)
      1:       begin e_we = fwe;       e_a = fa;       e_d = fd;       end
      2:       begin e_we = m_skid_we; e_a = m_skid_a; e_d = m_skid_d; end
      3:       begin e_we = hwe;       e_a = ha;       e_d = hd;       end
      default: begin e_we = 0;         e_a = '0;       e_d = '0;       end
    endcase
    chk_eq("f_gnt", f_gnt, win == 1);
    chk_eq("mem_en", mem_en, win != 0);
    chk_eq("mem_we", mem_we, e_we);
    if (win != 0) chk_eq("mem_addr", mem_addr, e_a);
    if (win != 0 && e_we) chk_eq("mem_wdata", mem_wdata, e_d);

    m_hpend = 0; m_fpend = 0;
    if (win != 0) begin
      if (e_we) mm[e_a] = e_d;
      else if (win == 1) begin m_fpend = 1; m_fnext = mm[e_a]; end
      else begin m_hpend = 1; m_hnext = mm[e_a]; end
    end
    was_full = m_skid_v;
    if (win == 2) m_skid_v = 0;
    if (hr && win != 3) begin
      if (!was_full) begin
        m_skid_v = 1; m_skid_we = hwe; m_skid_a = ha; m_skid_d = hd;
      end else begin
        m_ovf = 1;
      end
    end
    if (fr && win != 1) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
    else m_starve = 0;
    m_last_fgnt = (win == 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Host hogs the buffer back to back while the fabric waits for a read at 0x020.
  task automatic starve_seq(input logic [8:0] base, input logic [15:0] dbase);
    for (int k = 0; k < SM; k++) begin
      step(1, 1, base + 9'(k), dbase + 16'(k), 1, 0, 9'h020, '0);
      chk_eq("pre_force_gnt", f_gnt, 0);
    end
    step(1, 0, base, '0, 1, 0, 9'h020, '0);
    chk_eq("force_gnt", f_gnt, 1);
    chk_eq("force_addr", mem_addr, 9'h020);
  endtask

  task automatic do_reset();
    @(negedge clk);
    h_req = 0; f_req = 1; f_we = 1;
    reset_l = 0;
    #1;
    chk_eq("rst_h_busy", h_busy, 0);
    chk_eq("rst_h_rvalid", h_rvalid, 0);
    chk_eq("rst_f_rvalid", f_rvalid, 0);
    chk_eq("rst_h_ovf", h_ovf, 0);
    chk_eq("rst_h_rdata", h_rdata, 0);
    chk_eq("rst_f_rdata", f_rdata, 0);
    chk_eq("rst_mem_en", mem_en, 0);
    chk_eq("rst_f_gnt", f_gnt, 0);
    model_reset();
    repeat (2) @(negedge clk);
    f_req = 0; f_we = 0;
    reset_l = 1;
  endtask

  function automatic logic [8:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
  endfunction

  initial begin
    bit          f_act, hr;
    bit          f_we_r;
    logic [8:0]  f_a_r;
    logic [15:0] f_d_r;
    int          gap;
    for (int i = 0; i < 512; i++) mm[i] = init_val(9'(i));
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    f_req = 0; f_we = 0; f_addr = '0; f_wdata = '0;
    reset_l = 0;
    do_reset();
    idle(2);

    // Host write then read, direct path
    step(1, 1, 9'h010, 16'h1234, 0, 0, '0, '0);
    idle(2);
    step(1, 0, 9'h010, '0, 0, 0, '0, '0);
    idle(1);
    chk_eq("t1_rvalid", h_rvalid, 1);
    chk_eq("t1_rdata", h_rdata, 16'h1234);
    idle(1);
    chk_eq("t1_rvalid_pulse", h_rvalid, 0);
    chk_eq("t1_rdata_hold", h_rdata, 16'h1234);

    // Fabric read of preloaded word, no host traffic
    step(0, 0, '0, '0, 1, 0, 9'h1FF, '0);
    chk_eq("t2_gnt", f_gnt, 1);
    idle(1);
    chk_eq("t2_rvalid", f_rvalid, 1);
    chk_eq("t2_rdata", f_rdata, 16'hBEEF);

    // Same-cycle host write and fabric read of one address
    step(1, 1, 9'h040, 16'hAAAA, 1, 0, 9'h040, '0);
    chk_eq("t3_gnt0", f_gnt, 0);
    step(0, 0, '0, '0, 1, 0, 9'h040, '0);
    chk_eq("t3_gnt1", f_gnt, 1);
    idle(1);
    chk_eq("t3_rdata", f_rdata, 16'hAAAA);
    idle(2);

    // Starvation force, host read via skid, drop while skid full
    starve_seq(9'h030, 16'h3000);
    step(1, 1, 9'h031, 16'hDEAD, 0, 0, '0, '0);
    chk_eq("t4_busy", h_busy, 1);
    chk_eq("t4_skid_addr", mem_addr, 9'h030);
    idle(1);
    chk_eq("t4_skid_rvalid", h_rvalid, 1);
    chk_eq("t4_skid_rdata", h_rdata, 16'h3000);
    chk_eq("t4_ovf", h_ovf, 1);
    chk_eq("t4_busy_off", h_busy, 0);
    idle(3);
    chk_eq("t4_ovf_sticky", h_ovf, 1);
    step(1, 0, 9'h031, '0, 0, 0, '0, '0);
    idle(1);
    chk_eq("t4_no_drop_write", h_rdata, 16'h3001);
    idle(2);

    // Reset with skid full and a fabric read in flight
    starve_seq(9'h050, 16'h5000);
    do_reset();
    idle(1);
    chk_eq("t5_h_rvalid", h_rvalid, 0);
    chk_eq("t5_f_rvalid", f_rvalid, 0);
    chk_eq("t5_busy", h_busy, 0);
    starve_seq(9'h060, 16'h6000);
    idle(3);

    // Randomized traffic against the model
    f_act = 0; gap = 10; f_we_r = 0; f_a_r = '0; f_d_r = '0;
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        do_reset();
        f_act = 0;
      end
      if (!f_act && $urandom_range(0, 2) == 0) begin
        f_act = 1; f_we_r = 1'($urandom); f_a_r = rnd_addr(); f_d_r = 16'($urandom);
      end
      hr = (gap >= 3) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 8);
      step(hr, 1'($urandom), rnd_addr(), 16'($urandom), f_act, f_we_r, f_a_r, f_d_r);
      gap = hr ? 1 : gap + 1;
      if (m_last_fgnt) f_act = 0;
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
